fft_output_reorder: RTL and testbench

Output stage of the 32-point radix-2 FFT. It accepts one frame of N complex results from the butterfly array, in sign-magnitude format and bit-reversed order. It buffers the frame and streams it out in natural order, converted to two's complement, over a valid/ready handshake. It is the consumer end of the sign-magnitude datapath produced by the add/subtract units.

---
 rtl/fft_output_reorder.sv | 131 +++++++++++++
 tb/tb_fft_output_reorder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder.sv
// fft_output_reorder: buffers one bit-reversed frame of sign-magnitude FFT
// results and streams it out in natural order as two's complement values.
module fft_output_reorder #(
    parameter int unsigned number_bits = 22,
    parameter int unsigned N           = 32,
    parameter int unsigned Q           = 8,
    localparam int unsigned A          = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [number_bits-1:0] in_re,
    input  logic [number_bits-1:0] in_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [number_bits-1:0] out_re,
    output logic [number_bits-1:0] out_im,
    output logic [A-1:0]           out_index,
    output logic                   out_last,
    output logic                   busy
);

    // Q is informational only; reject nonsensical parameter sets at elaboration.
    if (Q > number_bits - 1 || N < 2 || (1 << A) != N) begin : g_param_check
        $error("fft_output_reorder: bad parameters");
    end

    typedef enum logic {StFill, StDrain} state_t;

    logic [number_bits-1:0] mem_re [N];
    logic [number_bits-1:0] mem_im [N];

    state_t       state;
    logic [A-1:0] wr_cnt;
    logic [A-1:0] rd_cnt;
    logic [A-1:0] rd_next;
    logic [A-1:0] wr_addr;
    logic         in_acc;
    logic         out_hs;

    function automatic logic [A-1:0] bitrev(input logic [A-1:0] x);
        logic [A-1:0] r;
        for (int j = 0; j < int'(A); j++) begin
            r[j] = x[A-1-j];
        end
        return r;
    endfunction

    // Negative zero maps to 0 naturally: -(0) wraps to 0.
    function automatic logic [number_bits-1:0] sm_to_tc(input logic [number_bits-1:0] x);
        logic [number_bits-1:0] mag;
        mag = {1'b0, x[number_bits-2:0]};
        return x[number_bits-1] ? -mag : mag;
    endfunction

    // Handshakes and addresses
    always_comb begin
        in_acc  = in_valid && in_ready;
        out_hs  = out_valid && out_ready;
        rd_next = rd_cnt + A'(1);
        wr_addr = bitrev(wr_cnt);
    end

    // Frame buffer write port, stored in sign-magnitude form
    always_ff @(posedge clk) begin
        if (!rst && in_acc) begin
            mem_re[wr_addr] <= in_re;
            mem_im[wr_addr] <= in_im;
        end
    end

    // Fill/drain control with registered handshake and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StFill;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            unique case (state)
                StFill: begin
                    if (in_acc) begin
                        if (wr_cnt == A'(N - 1)) begin
                            // Bin 0 sits at address 0 (written by the first accept);
                            // the final accept writes address N-1, so no collision.
                            wr_cnt    <= '0;
                            rd_cnt    <= '0;
                            state     <= StDrain;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                            out_re    <= sm_to_tc(mem_re[0]);
                            out_im    <= sm_to_tc(mem_im[0]);
                            out_index <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            wr_cnt <= wr_cnt + A'(1);
                        end
                    end
                end
                StDrain: begin
                    if (out_hs) begin
                        if (out_last) begin
                            state     <= StFill;
                            rd_cnt    <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            rd_cnt    <= rd_next;
                            out_re    <= sm_to_tc(mem_re[rd_next]);
                            out_im    <= sm_to_tc(mem_im[rd_next]);
                            out_index <= rd_next;
                            out_last  <= (rd_next == A'(N - 1));
                        end
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Self-checking bench for fft_output_reorder: table vectors, directed frames and
// randomized handshakes against a behavioural reorder/conversion model.
module tb_fft_output_reorder;

    localparam int NB = 22;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] in_re;
    logic [NB-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] out_re;
    logic [NB-1:0] out_im;
    logic [4:0]    out_index;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    fft_output_reorder #(
        .number_bits(NB),
        .N          (N),
        .Q          (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_re    (in_re),
        .in_im    (in_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_index(out_index),
        .out_last (out_last),
        .busy     (busy)
    );

    typedef struct {
        logic [NB-1:0] re;
        logic [NB-1:0] im;
        logic [NB-1:0] exp_re;
        logic [NB-1:0] exp_im;
    } vec_t;

    vec_t          tbl [8];
    logic [NB-1:0] fr_re [N];
    logic [NB-1:0] fr_im [N];
    logic [NB-1:0] exp_re [N];
    logic [NB-1:0] exp_im [N];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reverse the low 5 bits by repeated division
    function automatic int rev5(input int x);
        int r = 0;
        int v = x;
        for (int j = 0; j < 5; j++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    // Signed value of a sign-magnitude word, wrapped to NB bits
    function automatic logic [NB-1:0] conv(input logic [NB-1:0] x);
        int v;
        v = int'(x[NB-2:0]);
        if (x[NB-1]) v = -v;
        return NB'(v);
    endfunction

    task automatic build_expected();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                if (rev5(k) == i) begin
                    exp_re[i] = conv(fr_re[k]);
                    exp_im[i] = conv(fr_im[k]);
                end
    endtask

    task automatic fill(input int bubble_pct);
        int k = 0;
        int cyc = 0;
        while (k < N && cyc < 4000) begin
            @(negedge clk);
            chk("fill_out_valid", out_valid, 0);
            chk("fill_in_ready", in_ready, 1);
            in_valid = ($urandom_range(0, 99) >= bubble_pct);
            if (in_valid) begin
                in_re = fr_re[k];
                in_im = fr_im[k];
            end else begin
                in_re = NB'($urandom);
                in_im = NB'($urandom);
            end
            if (in_valid && in_ready) k++;
            cyc++;
        end
        if (k < N) chk("fill_timeout", k, N);
    endtask

    task automatic drain(input int ready_pct, input bit hold_valid, input int stop_at);
        int            i = 0;
        int            cyc = 0;
        bit            stalled = 0;
        logic [NB-1:0] pre, pim;
        logic [4:0]    pidx;
        logic          pl;
        while (i < stop_at && cyc < 4000) begin
            @(negedge clk);
            chk("drain_out_valid", out_valid, 1);
            chk("drain_in_ready", in_ready, 0);
            chk("drain_busy", busy, 1);
            if (stalled) begin
                chk("stall_re", out_re, pre);
                chk("stall_im", out_im, pim);
                chk("stall_index", out_index, pidx);
                chk("stall_last", out_last, pl);
            end
            out_ready = ($urandom_range(0, 99) < ready_pct);
            in_valid  = hold_valid;
            in_re     = NB'($urandom);
            in_im     = NB'($urandom);
            if (out_valid && out_ready) begin
                chk("out_index", out_index, i);
                chk("out_re", out_re, exp_re[i]);
                chk("out_im", out_im, exp_im[i]);
                chk("out_last", out_last, (i == N - 1));
                i++;
                stalled = 0;
            end else begin
                stalled = out_valid;
                pre = out_re; pim = out_im; pidx = out_index; pl = out_last;
            end
            cyc++;
        end
        if (i < stop_at) chk("drain_timeout", i, stop_at);
        if (stop_at == N) begin
            @(negedge clk);
            out_ready = 0;
            in_valid  = 0;
            chk("post_in_ready", in_ready, 1);
            chk("post_out_valid", out_valid, 0);
            chk("post_busy", busy, 0);
        end
    endtask

    task automatic reorder_frame();
        for (int k = 0; k < N; k++) begin
            fr_re[k] = NB'(k);
            fr_im[k] = NB'(k) | 22'h200000;
        end
        build_expected();
    endtask

    task automatic random_frame();
        for (int k = 0; k < N; k++) begin
            fr_re[k] = NB'($urandom);
            fr_im[k] = NB'($urandom);
        end
        if ($urandom_range(0, 1) == 1) fr_re[3] = 22'h200000;
        build_expected();
    endtask

    initial begin
        tbl[0] = '{22'h200000, 22'h3FFFFF, 22'h000000, 22'h200001};
        tbl[1] = '{22'h1FFFFF, 22'h000000, 22'h1FFFFF, 22'h000000};
        tbl[2] = '{22'h200001, 22'h000001, 22'h3FFFFF, 22'h000001};
        tbl[3] = '{22'h000005, 22'h200005, 22'h000005, 22'h3FFFFB};
        tbl[4] = '{22'h2ABCDE, 22'h0ABCDE, 22'h354322, 22'h0ABCDE};
        tbl[5] = '{22'h300000, 22'h100000, 22'h300000, 22'h100000};
        tbl[6] = '{22'h200010, 22'h000010, 22'h3FFFF0, 22'h000010};
        tbl[7] = '{22'h000000, 22'h200000, 22'h000000, 22'h000000};

        // Reset held 3 cycles with random inputs
        rst = 1; in_valid = 0; out_ready = 0; in_re = '0; in_im = '0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            in_re     = NB'($urandom);
            in_im     = NB'($urandom);
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_re", out_re, 0);
            chk("rst_out_im", out_im, 0);
            chk("rst_out_index", out_index, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_busy", busy, 0);
        end
        rst = 0; in_valid = 0; out_ready = 0;

        // Gapless reorder frame
        reorder_frame();
        fill(0);
        drain(100, 0, N);

        // Same frame with input bubbles must give identical output
        fill(40);
        drain(100, 0, N);

        // Conversion edge table at arrival positions 0..7
        random_frame();
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = tbl[k].re;
            fr_im[k] = tbl[k].im;
        end
        for (int k = 0; k < 8; k++) begin
            exp_re[rev5(k)] = tbl[k].exp_re;
            exp_im[rev5(k)] = tbl[k].exp_im;
        end
        fill(0);
        drain(100, 0, N);

        // Backpressure at 30% with in_valid held high, then an immediate next frame
        random_frame();
        fill(0);
        drain(30, 1, N);
        random_frame();
        fill(0);
        drain(100, 0, N);

        // Reset after bin 10's handshake
        random_frame();
        fill(20);
        drain(100, 0, 11);
        @(negedge clk);
        rst = 1; out_ready = 0; in_valid = 0;
        @(negedge clk);
        rst = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_index", out_index, 0);
        reorder_frame();
        fill(0);
        drain(100, 0, N);

        // Random bubbles and random backpressure together
        for (int f = 0; f < 3; f++) begin
            random_frame();
            fill(30);
            drain(60, f[0], N);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
